// File: rtl/window_generator.sv
// window_generator
// Builds a 5x5 sliding window from column taps supplied by an external line
// buffer and tracks the window position inside a square frame whose width is
// selected per frame by mode.
//
// Ports
//   clk         : rising-edge clock
//   rst_n       : asynchronous active-low reset
//   mode        : frame width select (000=28, 001=14, 010=12, others=28)
//   in_valid    : a column beat is present on line_in_0..4
//   line_in_0..4: column taps, line_in_0 oldest row, line_in_4 current row
//   win_out     : window, element (r,c) at [(r*5+c)*DATA_WIDTH +: DATA_WIDTH]
//   win_valid   : win_out holds a complete window this cycle
//   win_row/col : top-left coordinates of the current window
//   frame_done  : pulses with the last window of a frame
module window_generator #(
  parameter int DATA_WIDTH = 8,
  parameter int K          = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [2:0]                   mode,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        line_in_0,
  input  logic [DATA_WIDTH-1:0]        line_in_1,
  input  logic [DATA_WIDTH-1:0]        line_in_2,
  input  logic [DATA_WIDTH-1:0]        line_in_3,
  input  logic [DATA_WIDTH-1:0]        line_in_4,
  output logic [K*K*DATA_WIDTH-1:0]    win_out,
  output logic                         win_valid,
  output logic [4:0]                   win_row,
  output logic [4:0]                   win_col,
  output logic                         frame_done
);

  localparam logic [4:0] EDGE = 5'(K - 1);

  logic [DATA_WIDTH-1:0] r_win [K][K];
  logic [DATA_WIDTH-1:0] w_col [K];
  logic [4:0]            r_row;
  logic [4:0]            r_col;
  logic [4:0]            r_width;
  logic [4:0]            w_width;
  logic                  w_first;
  logic                  w_col_last;
  logic                  w_row_last;
  logic                  w_trig;

  function automatic logic [4:0] decode_width(input logic [2:0] m);
    case (m)
      3'b001:  return 5'd14;
      3'b010:  return 5'd12;
      default: return 5'd28;
    endcase
  endfunction

  always_comb begin
    w_col[0] = line_in_0;
    w_col[1] = line_in_1;
    w_col[2] = line_in_2;
    w_col[3] = line_in_3;
    w_col[4] = line_in_4;
  end

  // The first beat of a frame already wraps against the freshly selected
  // width, so the live mode value is used until it has been latched.
  assign w_first    = (r_row == '0) && (r_col == '0);
  assign w_width    = w_first ? decode_width(mode) : r_width;
  assign w_col_last = (r_col == w_width - 5'd1);
  assign w_row_last = (r_row == w_width - 5'd1);
  assign w_trig     = in_valid && (r_row >= EDGE) && (r_col >= EDGE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row      <= '0;
      r_col      <= '0;
      r_width    <= 5'd28;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
      for (int unsigned r = 0; r < K; r++)
        for (int unsigned c = 0; c < K; c++)
          r_win[r][c] <= '0;
    end else begin
      win_valid  <= w_trig;
      frame_done <= w_trig && w_row_last && w_col_last;
      if (w_trig) begin
        win_row <= r_row - EDGE;
        win_col <= r_col - EDGE;
      end
      if (in_valid) begin
        if (w_first)
          r_width <= decode_width(mode);
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 5'd1;
        end else begin
          r_col <= r_col + 5'd1;
        end
        for (int unsigned r = 0; r < K; r++) begin
          for (int unsigned c = 0; c < K - 1; c++)
            r_win[r][c] <= r_win[r][c+1];
          r_win[r][K-1] <= w_col[r];
        end
      end
    end
  end

  always_comb begin
    win_out = '0;
    for (int unsigned r = 0; r < K; r++)
      for (int unsigned c = 0; c < K; c++)
        win_out[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = r_win[r][c];
  end

endmodule

// File: tb/tb_window_generator.sv
// Scoreboard bench for window_generator: each triggering beat pushes the
// expected window (computed directly from the pixel function) and position;
// the monitor pops on every win_valid cycle. Per-frame statistics are checked
// against fixed expected constants.
module tb_window_generator;

  localparam int DW = 8;
  localparam int WB = 25 * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    mode;
  logic          in_valid;
  logic [DW-1:0] line_in_0, line_in_1, line_in_2, line_in_3, line_in_4;
  logic [WB-1:0] win_out;
  logic          win_valid;
  logic [4:0]    win_row, win_col;
  logic          frame_done;

  window_generator #(.DATA_WIDTH(DW), .K(5)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid),
    .line_in_0(line_in_0), .line_in_1(line_in_1), .line_in_2(line_in_2),
    .line_in_3(line_in_3), .line_in_4(line_in_4),
    .win_out(win_out), .win_valid(win_valid), .win_row(win_row),
    .win_col(win_col), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]    row;
    logic [4:0]    col;
    logic          fd;
    logic [WB-1:0] win;
  } item_t;

  typedef struct {
    int cnt;
    int e00;
    int e44;
    int fdr;
    int fdc;
  } stat_t;

  item_t sb[$];
  stat_t stats[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_fd     = 0;

  // bench-side model state
  int   m_row = 0, m_col = 0, m_w = 28;
  logic tb_trig = 1'b0;
  logic exp_v;

  task automatic chk(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int wdec(input logic [2:0] m);
    case (m)
      3'b001:  return 14;
      3'b010:  return 12;
      default: return 28;
    endcase
  endfunction

  function automatic logic [DW-1:0] f(input int y, input int x);
    if (y < 0) return '0;
    return DW'((y * m_w + x + 1) % 256);
  endfunction

  task automatic drive_beat();
    item_t it;
    if (m_row == 0 && m_col == 0) m_w = wdec(mode);
    in_valid  = 1'b1;
    line_in_0 = f(m_row - 4, m_col);
    line_in_1 = f(m_row - 3, m_col);
    line_in_2 = f(m_row - 2, m_col);
    line_in_3 = f(m_row - 1, m_col);
    line_in_4 = f(m_row,     m_col);
    tb_trig   = (m_row >= 4) && (m_col >= 4);
    if (tb_trig) begin
      it.row = 5'(m_row - 4);
      it.col = 5'(m_col - 4);
      it.fd  = (m_row == m_w - 1) && (m_col == m_w - 1);
      it.win = '0;
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          it.win[(r*5+c)*DW +: DW] = f(m_row - 4 + r, m_col - 4 + c);
      sb.push_back(it);
    end
    if (m_col == m_w - 1) begin
      m_col = 0;
      m_row = (m_row == m_w - 1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    tb_trig  = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_win_out"},    win_out,          '0);
    chk({tag, "_win_valid"},  WB'(win_valid),   '0);
    chk({tag, "_win_row"},    WB'(win_row),     '0);
    chk({tag, "_win_col"},    WB'(win_col),     '0);
    chk({tag, "_frame_done"}, WB'(frame_done),  '0);
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    tb_trig  = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_reset_outputs("midrst");
    sb.delete();
    m_row = 0; m_col = 0; m_w = 28;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input logic [2:0] m, input int gap_at, input int gap_len,
                           input int sw_at, input logic [2:0] m2, input int rst_at);
    int b = 0;
    mode = m;
    do begin
      if (b == sw_at) mode = m2;
      drive_beat();
      if (b == gap_at) idle(gap_len);
      if (b == rst_at) begin
        pulse_reset();
        return;
      end
      b++;
    end while (!(m_row == 0 && m_col == 0));
  endtask

  task automatic check_frame(input string tag, input int cnt, input int e44, input int last);
    stat_t s;
    if (stats.size() == 0) begin
      chk({tag, "_stats_present"}, '0, WB'(1));
      return;
    end
    s = stats.pop_front();
    chk({tag, "_count"}, WB'(s.cnt), WB'(cnt));
    chk({tag, "_e00"},   WB'(s.e00), WB'(1));
    chk({tag, "_e44"},   WB'(s.e44), WB'(e44));
    chk({tag, "_fdrow"}, WB'(s.fdr), WB'(last));
    chk({tag, "_fdcol"}, WB'(s.fdc), WB'(last));
  endtask

  // expected win_valid: registered copy of "driven beat triggers"
  always @(posedge clk or negedge rst_n)
    if (!rst_n) exp_v <= 1'b0;
    else        exp_v <= tb_trig;

  int frame_wins = 0;
  int cur_e00 = 0, cur_e44 = 0;

  always @(negedge clk) begin : mon
    item_t it;
    stat_t s;
    if (!rst_n) begin
      frame_wins = 0;
    end else begin
      chk("win_valid", WB'(win_valid), WB'(exp_v));
      if (win_valid) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", '0, WB'(1));
        end else begin
          it = sb.pop_front();
          chk("win_row",    WB'(win_row),    WB'(it.row));
          chk("win_col",    WB'(win_col),    WB'(it.col));
          chk("frame_done", WB'(frame_done), WB'(it.fd));
          chk("win_out",    win_out,         it.win);
        end
        if (frame_wins == 0) begin
          cur_e00 = int'(win_out[0 +: DW]);
          cur_e44 = int'(win_out[24*DW +: DW]);
        end
        frame_wins++;
        if (frame_done) begin
          s.cnt = frame_wins; s.e00 = cur_e00; s.e44 = cur_e44;
          s.fdr = int'(win_row); s.fdc = int'(win_col);
          stats.push_back(s);
          frame_wins = 0;
          n_fd++;
        end
      end else begin
        chk("frame_done_idle", WB'(frame_done), '0);
      end
    end
  end

  initial begin
    int fd0;
    rst_n = 1'b0; mode = 3'b000; in_valid = 1'b0;
    line_in_0 = '0; line_in_1 = '0; line_in_2 = '0; line_in_3 = '0; line_in_4 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // full W=28 frame, then W=14 frame
    run_frame(3'b000, -1, 0, -1, 3'b000, -1); idle(3);
    check_frame("w28", 576, 117, 23);
    run_frame(3'b001, -1, 0, -1, 3'b001, -1); idle(3);
    check_frame("w14", 100, 61, 9);

    // input gap after beat 120
    run_frame(3'b000, 120, 3, -1, 3'b000, -1); idle(3);
    check_frame("gap", 576, 117, 23);

    // mode change mid-frame applies from the next frame only
    run_frame(3'b000, -1, 0, 50, 3'b001, -1); idle(3);
    check_frame("sw_a", 576, 117, 23);
    run_frame(3'b001, -1, 0, -1, 3'b001, -1); idle(3);
    check_frame("sw_b", 100, 61, 9);

    // reset mid-frame, then a complete frame
    run_frame(3'b000, -1, 0, -1, 3'b000, 300);
    chk("abort_no_stats", WB'(stats.size()), '0);
    run_frame(3'b000, -1, 0, -1, 3'b000, -1); idle(3);
    check_frame("postrst", 576, 117, 23);

    // two back-to-back W=12 frames
    fd0 = n_fd;
    run_frame(3'b010, -1, 0, -1, 3'b010, -1);
    run_frame(3'b010, -1, 0, -1, 3'b010, -1); idle(3);
    check_frame("w12_a", 64, 53, 7);
    check_frame("w12_b", 64, 53, 7);
    chk("w12_fd_pulses", WB'(n_fd - fd0), WB'(2));

    chk("sb_drained", WB'(sb.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
